// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the sequential SubBytes block.
// Optional S-box output register stage: define SUB_BYTES_SEQ_PIPE_REG_EN.
package aes_pkg;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_word_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} sbseq_state_e;

   localparam int NUM_COLS = 4;
   localparam int COL_W    = $clog2(NUM_COLS);

   localparam logic [7:0] AFFINE_C     = 8'h63;
   localparam logic [7:0] INV_AFFINE_C = 8'h05;
   localparam logic [7:0] GF_POLY_LOW  = 8'h1B;

   function automatic logic [7:0] rotl8(input logic [7:0] a, input int unsigned n);
      return (a << n) | (a >> (8 - n));
   endfunction

   function automatic logic [7:0] gfXtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY_LOW : 8'h00);
   endfunction

   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = gfXtime(sh);
      end
      return acc;
   endfunction

   // x^254 is x^-1 for nonzero x and maps 0 to 0, exactly what the S-box needs
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 0; i < 7; i++) begin
         sq  = gfMul(sq, sq);
         acc = gfMul(acc, sq);
      end
      return acc;
   endfunction

endpackage

// File: rtl/composite_field_s_box.sv
// Single-byte AES S-box, forward (i_enc_dec = 1) or inverse (i_enc_dec = 0),
// built around a shared GF(2^8) multiplicative inverse.
module composite_field_s_box
   import aes_pkg::*;
(
   input  logic       i_enc_dec,
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);

   logic [7:0] w_invAffine;
   logic [7:0] w_invIn;
   logic [7:0] w_inv;
   logic [7:0] w_fwdAffine;

   // Inverse direction undoes the affine map first, forward applies it last
   assign w_invAffine = rotl8(i_byte, 1) ^ rotl8(i_byte, 3) ^ rotl8(i_byte, 6) ^ INV_AFFINE_C;
   assign w_invIn     = i_enc_dec ? i_byte : w_invAffine;
   assign w_inv       = gfInv(w_invIn);
   assign w_fwdAffine = w_inv ^ rotl8(w_inv, 1) ^ rotl8(w_inv, 2) ^ rotl8(w_inv, 3)
                        ^ rotl8(w_inv, 4) ^ AFFINE_C;
   assign o_byte      = i_enc_dec ? w_fwdAffine : w_inv;

endmodule

// File: rtl/sub_bytes_seq.sv
// Column-serial AES SubBytes/InvSubBytes over a 128-bit state using four shared S-boxes.
// Define SUB_BYTES_SEQ_PIPE_REG_EN to register the S-box outputs before write-back.
module sub_bytes_seq
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic         in_enc_dec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

   sbseq_state_e     r_fsm;
   aes_state_t       r_state;
   logic             r_mode;
   logic [COL_W-1:0] r_colCnt;
   logic             r_inReady;
   logic             r_outValid;
   logic             r_busy;

   aes_word_t        w_colIn;
   aes_word_t        w_colSub;

`ifdef SUB_BYTES_SEQ_PIPE_REG_EN
   aes_word_t        r_pipeWord;
   logic [COL_W-1:0] r_pipeCol;
   logic             r_pipeValid;
   logic             r_drain;
`endif

   assign w_colIn = r_state[{r_colCnt, 5'd0} +: 32];

   for (genvar b = 0; b < 4; b++) begin : g_sbox
      composite_field_s_box u_sbox (
         .i_enc_dec (r_mode),
         .i_byte    (w_colIn[8*b +: 8]),
         .o_byte    (w_colSub[8*b +: 8])
      );
   end

   // Handshake flags are registered alongside the state so they change only with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm      <= IDLE;
         r_state    <= '0;
         r_mode     <= 1'b0;
         r_colCnt   <= '0;
         r_inReady  <= 1'b1;
         r_outValid <= 1'b0;
         r_busy     <= 1'b0;
`ifdef SUB_BYTES_SEQ_PIPE_REG_EN
         r_pipeWord  <= '0;
         r_pipeCol   <= '0;
         r_pipeValid <= 1'b0;
         r_drain     <= 1'b0;
`endif
      end else begin
         case (r_fsm)
            IDLE: begin
               if (in_valid) begin
                  r_state   <= in_data;
                  r_mode    <= in_enc_dec;
                  r_colCnt  <= '0;
                  r_fsm     <= RUN;
                  r_inReady <= 1'b0;
                  r_busy    <= 1'b1;
               end
            end
            RUN: begin
`ifdef SUB_BYTES_SEQ_PIPE_REG_EN
               // Issue one column per cycle; the extra drain cycle retires the last one
               if (r_pipeValid) r_state[{r_pipeCol, 5'd0} +: 32] <= r_pipeWord;
               if (r_drain) begin
                  r_pipeValid <= 1'b0;
                  r_drain     <= 1'b0;
                  r_fsm       <= DONE;
                  r_outValid  <= 1'b1;
               end else begin
                  r_pipeWord  <= w_colSub;
                  r_pipeCol   <= r_colCnt;
                  r_pipeValid <= 1'b1;
                  r_colCnt    <= r_colCnt + COL_W'(1);
                  if (r_colCnt == LAST_COL) r_drain <= 1'b1;
               end
`else
               r_state[{r_colCnt, 5'd0} +: 32] <= w_colSub;
               r_colCnt <= r_colCnt + COL_W'(1);
               if (r_colCnt == LAST_COL) begin
                  r_fsm      <= DONE;
                  r_outValid <= 1'b1;
               end
`endif
            end
            DONE: begin
               if (out_ready) begin
                  r_fsm      <= IDLE;
                  r_outValid <= 1'b0;
                  r_inReady  <= 1'b1;
                  r_busy     <= 1'b0;
               end
            end
            default: r_fsm <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_inReady;
   assign out_valid = r_outValid;
   assign busy      = r_busy;
   assign out_data  = r_outValid ? r_state : '0;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Self-checking bench for sub_bytes_seq: known-answer table, randomized round trips against
// a table-based S-box model, backpressure and mid-run reset sequences.
module tb_sub_bytes_seq;

`ifdef SUB_BYTES_SEQ_PIPE_REG_EN
   localparam int EXP_LAT = 5;
`else
   localparam int EXP_LAT = 4;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic         in_enc_dec = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_data;
   logic         busy;

   int testsRun = 0;
   int testsFailed = 0;

   logic [7:0] refFwd[256];
   logic [7:0] refInv[256];

   typedef struct {
      string        name;
      logic [127:0] data;
      logic         mode;
      logic [127:0] expected;
   } vector_t;

   vector_t vectors[8];

   sub_bytes_seq dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_enc_dec (in_enc_dec),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Carry-less multiply then reduce by x^8+x^4+x^3+x+1
   function automatic int refMul(input int a, input int b);
      int p;
      p = 0;
      for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
      for (int k = 14; k >= 8; k--) if (((p >> k) & 1) != 0) p = p ^ ('h11B << (k - 8));
      return p;
   endfunction

   function automatic int refAffine(input int x);
      int r;
      int bitVal;
      r = 0;
      for (int i = 0; i < 8; i++) begin
         bitVal = ((x >> i) ^ (x >> ((i + 4) % 8)) ^ (x >> ((i + 5) % 8))
                   ^ (x >> ((i + 6) % 8)) ^ (x >> ((i + 7) % 8)) ^ ('h63 >> i)) & 1;
         r = r | (bitVal << i);
      end
      return r;
   endfunction

   task automatic buildTables();
      int inv;
      for (int x = 0; x < 256; x++) begin
         inv = 0;
         for (int y = 1; y < 256; y++) if (refMul(x, y) == 1) inv = y;
         refFwd[x] = 8'(refAffine(inv));
      end
      for (int x = 0; x < 256; x++) refInv[refFwd[x]] = 8'(x);
   endtask

   function automatic logic [127:0] modelBlock(input logic [127:0] d, input logic mode);
      logic [127:0] r;
      r = '0;
      for (int k = 0; k < 16; k++)
         r[8*k +: 8] = mode ? refFwd[d[8*k +: 8]] : refInv[d[8*k +: 8]];
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   // One full block through the handshake; disturb scrambles inputs while the block is in flight
   task automatic applyStimulus(input logic [127:0] data, input logic mode, input bit disturb,
                                output logic [127:0] result);
      int lat;
      in_data    = data;
      in_enc_dec = mode;
      in_valid   = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         if (disturb) begin
            in_data    = {$urandom, $urandom, $urandom, $urandom};
            in_enc_dec = 1'($urandom);
            in_valid   = 1'($urandom);
         end
         @(posedge clk); #1;
         lat++;
      end
      in_valid = 1'b0;
      checkOutput("latency", 128'(lat), 128'(EXP_LAT));
      checkOutput("in_ready in DONE", 128'(in_ready), 128'(0));
      result = out_data;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("idle after output", 128'({out_valid, in_ready, busy}), 128'(3'b010));
   endtask

   initial begin
      logic [127:0] res;
      logic [127:0] enc;
      logic [127:0] orig;
      logic [127:0] expBp;
      int           lat;
      bit           sawValid;

      buildTables();

      vectors[0] = '{"zero enc",    128'h0,              1'b1, {16{8'h63}}};
      vectors[1] = '{"known enc",   128'h53,             1'b1, {{15{8'h63}}, 8'hED}};
      vectors[2] = '{"known dec",   {{15{8'h63}}, 8'hED}, 1'b0, 128'h53};
      vectors[3] = '{"all63 dec",   {16{8'h63}},         1'b0, 128'h0};
      vectors[4] = '{"ones enc",    {16{8'h01}},         1'b1, {16{8'h7C}}};
      vectors[5] = '{"ramp enc",    128'h0f0e0d0c0b0a09080706050403020100, 1'b1,
                     128'h76abd7fe2b670130c56f6bf27b777c63};
      vectors[6] = '{"ramp dec",    128'h76abd7fe2b670130c56f6bf27b777c63, 1'b0,
                     128'h0f0e0d0c0b0a09080706050403020100};
      vectors[7] = '{"ff enc",      {16{8'hFF}},         1'b1, {16{8'h16}}};

      #12;
      checkOutput("reset flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
      checkOutput("reset out_data", out_data, 128'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 8; i++) begin
         applyStimulus(vectors[i].data, vectors[i].mode, 1'b0, res);
         checkOutput(vectors[i].name, res, vectors[i].expected);
      end

      // Backpressure: hold DONE for ten cycles while hammering in_valid
      expBp = 128'h76abd7fe2b670130c56f6bf27b777c63;
      in_data = 128'h0f0e0d0c0b0a09080706050403020100;
      in_enc_dec = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checkOutput("busy in RUN", 128'({busy, in_ready, out_valid}), 128'(3'b100));
      checkOutput("out_data zero in RUN", out_data, 128'h0);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      checkOutput("bp latency", 128'(lat), 128'(EXP_LAT));
      for (int c = 0; c < 10; c++) begin
         in_valid   = 1'b1;
         in_data    = {$urandom, $urandom, $urandom, $urandom};
         in_enc_dec = 1'($urandom);
         @(posedge clk); #1;
         checkOutput("bp data stable", out_data, expBp);
         checkOutput("bp flags", 128'({out_valid, in_ready, busy}), 128'(3'b101));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checkOutput("bp release flags", 128'({out_valid, in_ready, busy}), 128'(3'b010));
      checkOutput("bp release data", out_data, 128'h0);

      // Reset in the middle of RUN with two columns already processed
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_enc_dec = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async reset flags", 128'({in_ready, out_valid, busy}), 128'(3'b100));
      checkOutput("async reset data", out_data, 128'h0);
      #10 rst_n = 1'b1;
      sawValid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) sawValid = 1'b1;
      end
      checkOutput("no valid after reset", 128'(sawValid), 128'(0));
      applyStimulus(vectors[1].data, 1'b1, 1'b0, res);
      checkOutput("post-reset block", res, vectors[1].expected);

      // Randomized round trips with inputs scrambled while each block is in flight
      for (int n = 0; n < 1000; n++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         applyStimulus(orig, 1'b1, 1'b1, enc);
         checkOutput("random enc", enc, modelBlock(orig, 1'b1));
         applyStimulus(enc, 1'b0, 1'b1, res);
         checkOutput("random round trip", res, orig);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/sub_bytes_seq.md
SUB_BYTES_SEQ -- requirements
Module: sub_bytes_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  upstream offers a 128-bit state.
REQ-005 in_ready  output  1  block accepts a state; transfer occurs when in_valid && in_ready at a rising edge.
REQ-006 in_data  input  128  AES state; byte k at bits [8k+7:8k]; column c = bits [32c+31:32c].
REQ-007 in_enc_dec  input  1  1 = SubBytes, 0 = InvSubBytes; sampled only on transfer.
REQ-008 out_valid  output  1  substituted state available.
REQ-009 out_ready  input  1  downstream accepts; transfer occurs when out_valid && out_ready at a rising edge.
REQ-010 out_data  output  128  substituted state; same byte ordering as in_data.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE, the block SHALL hold in_ready = 1, out_valid = 0 and busy = 0.
REQ-014 On an input transfer, the block SHALL latch in_data into the state register, latch in_enc_dec into the mode register, clear col_cnt (2 bits) and enter RUN.
REQ-015 In RUN, in_ready SHALL be 0, and each cycle SHALL substitute column col_cnt through 4 shared S-boxes in the latched mode, writing the result back to the same column.
REQ-016 In RUN, col_cnt SHALL increment each cycle; after column 3 is written, the FSM SHALL enter DONE and col_cnt SHALL wrap to 0.
REQ-017 Without the pipeline macro, out_valid SHALL rise exactly 4 rising edges after the input-transfer edge.
REQ-018 In DONE, out_valid = 1 and out_data = state register; both SHALL be held stable until an output transfer occurs.
REQ-019 On an output transfer, the FSM SHALL return to IDLE; in_ready SHALL be 0 in that DONE cycle (no same-cycle accept). Peak throughput is 1 block per 6 cycles.
REQ-020 Changes on in_enc_dec or in_data outside the transfer edge SHALL have no effect.
REQ-021 in_valid during RUN or DONE SHALL be ignored (not accepted).
REQ-022 out_data SHALL be 0 whenever out_valid = 0.

Reset
REQ-023 While rst_n = 0, the block SHALL clear the state register, mode, col_cnt and FSM (to IDLE) immediately, independent of clk.
REQ-024 Reset values SHALL be: in_ready = 1, out_valid = 0, out_data = 0, busy = 0.
REQ-025 Reset in RUN or DONE SHALL discard the block in flight; no out_valid pulse follows the reset.

Configuration
REQ-026 Macro SUB_BYTES_SEQ_PIPE_REG_EN SHALL control an S-box output register stage.
REQ-027 With SUB_BYTES_SEQ_PIPE_REG_EN defined, a 32-bit register SHALL sit between the S-box outputs and the state write-back.
REQ-028 With SUB_BYTES_SEQ_PIPE_REG_EN defined, RUN SHALL last 5 cycles (col_cnt 0..3 issue, one drain cycle), and out_valid SHALL rise 5 edges after the input-transfer edge.
REQ-029 Without SUB_BYTES_SEQ_PIPE_REG_EN, the S-box output SHALL write back combinationally in the same cycle, per REQ-017.

Structure
REQ-030 Package aes_pkg SHALL hold typedef aes_state_t (logic [127:0]) and typedef aes_word_t (logic [31:0]).
REQ-031 Package aes_pkg SHALL hold enum sbseq_state_e {IDLE, RUN, DONE} and localparam NUM_COLS = 4.
REQ-032 The block SHALL instantiate the existing composite_field_s_box sub-module 4 times (one per byte of the active column), sharing the latched mode as enc_dec. No other sub-modules are allowed.

Verification
REQ-033 Zero block: in_data = 0, enc -> out_data = 0x6363…63 (16 bytes) at the latency in REQ-017/REQ-028.
REQ-034 Known bytes: byte 0 = 0x53, byte 15 = 0x00, other bytes 0x00, enc -> byte 0 = 0xED, others 0x63; same block with all bytes XOR-inverted through dec of 0xED/0x63 -> 0x53/0x00.
REQ-035 Round trip: random 1000 blocks, enc then dec -> original in_data; mode toggled on in_enc_dec during RUN -> result unchanged.
REQ-036 Backpressure: out_ready = 0 for 10 cycles in DONE -> out_data stable, in_ready = 0, and in_valid is ignored; out_ready = 1 -> IDLE next cycle.
REQ-037 Reset: assert rst_n = 0 mid-RUN (col_cnt = 2) -> outputs at reset values asynchronously, no out_valid afterwards, and the next block is processed correctly.
